// File: rtl/dual_issue_sequencer_if.sv
// Pair handshake between the instruction queue and the dual-issue sequencer.
interface dual_issue_sequencer_if;
  localparam int unsigned REG_W = 5;

  logic             pair_valid;
  logic             valid1;
  logic [REG_W-1:0] rd0;
  logic [REG_W-1:0] rs1_0;
  logic [REG_W-1:0] rs2_0;
  logic [REG_W-1:0] rd1;
  logic [REG_W-1:0] rs1_1;
  logic [REG_W-1:0] rs2_1;
  logic             wr0;
  logic             wr1;
  logic             use1_1;
  logic             use2_1;
  logic             issue0;
  logic             issue1;
  logic             pair_ack;

  // Queue side: presents the pair, receives issue pulses and the pop.
  modport master (
    output pair_valid, valid1, rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1,
    output wr0, wr1, use1_1, use2_1,
    input  issue0, issue1, pair_ack
  );

  // Sequencer side.
  modport slave (
    input  pair_valid, valid1, rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1,
    input  wr0, wr1, use1_1, use2_1,
    output issue0, issue1, pair_ack
  );
endinterface

// File: rtl/dual_issue_sequencer.sv
// Dual-issue sequencer: issues an instruction pair together when independent,
// otherwise splits it across two issue ticks. Tracks dual/split counts.
module dual_issue_sequencer (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    flush,
  dual_issue_sequencer_if.slave   bus,
  output logic                    busy,
  output logic [15:0]             dual_cnt,
  output logic [15:0]             split_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic             issue0_nxt;
  logic             issue1_nxt;
  logic             ack_nxt;
  logic             dual_inc;
  logic             split_inc;
  logic             raw;
  logic             waw;
  logic             hazard;
  logic [CNT_W-1:0] dual_cnt_q;
  logic [CNT_W-1:0] split_cnt_q;

  // Slot1 dependence on slot0; x0 writes never create a dependence.
  always_comb begin
    raw    = bus.wr0 & (bus.rd0 != '0) &
             ((bus.use1_1 & (bus.rs1_1 == bus.rd0)) |
              (bus.use2_1 & (bus.rs2_1 == bus.rd0)));
    waw    = bus.wr0 & bus.wr1 & (bus.rd0 != '0) & (bus.rd0 == bus.rd1);
    hazard = bus.valid1 & (raw | waw);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pulse decode; flush wins over en and suppresses all pulses.
  always_comb begin
    state_nxt  = state;
    issue0_nxt = 1'b0;
    issue1_nxt = 1'b0;
    ack_nxt    = 1'b0;
    dual_inc   = 1'b0;
    split_inc  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (bus.pair_valid) begin
            issue0_nxt = 1'b1;
            if (!bus.valid1) begin
              ack_nxt = 1'b1;
            end else if (hazard) begin
              split_inc = 1'b1;
              state_nxt = SPLIT;
            end else begin
              issue1_nxt = 1'b1;
              ack_nxt    = 1'b1;
              dual_inc   = 1'b1;
            end
          end
        end
        SPLIT: begin
          // Queue holds the pair until ack, so pair_valid is not consulted.
          issue1_nxt = 1'b1;
          ack_nxt    = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered one-clk issue/ack pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.issue0   <= 1'b0;
      bus.issue1   <= 1'b0;
      bus.pair_ack <= 1'b0;
    end else begin
      bus.issue0   <= issue0_nxt;
      bus.issue1   <= issue1_nxt;
      bus.pair_ack <= ack_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dual_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      if (dual_inc && (dual_cnt_q != CNT_MAX)) begin
        dual_cnt_q <= dual_cnt_q + CNT_W'(1);
      end
      if (split_inc && (split_cnt_q != CNT_MAX)) begin
        split_cnt_q <= split_cnt_q + CNT_W'(1);
      end
    end
  end

  // busy follows state directly; counters are driven straight from their registers.
  always_comb begin
    busy      = (state == SPLIT);
    dual_cnt  = dual_cnt_q;
    split_cnt = split_cnt_q;
  end

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Directed bench for dual_issue_sequencer with hand-computed expectations.
module tb_dual_issue_sequencer;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic [15:0] dual_cnt;
  logic [15:0] split_cnt;
  int          checks = 0;
  int          errors = 0;

  dual_issue_sequencer_if bus();

  dual_issue_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .bus       (bus),
    .busy      (busy),
    .dual_cnt  (dual_cnt),
    .split_cnt (split_cnt)
  );

  always #5 clk = ~clk;

  // Compare {issue0, issue1, pair_ack, busy}.
  task automatic chk_out(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.issue0, bus.issue1, bus.pair_ack, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={i0,i1,ack,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare {dual_cnt, split_cnt}.
  task automatic chk_cnt(input string tag, input logic [15:0] exp_dual, input logic [15:0] exp_split);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {dual_cnt, split_cnt};
    exp = {exp_dual, exp_split};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed dual=%h split=%h expected dual=%h split=%h",
             tag, obs[31:16], obs[15:0], exp[31:16], exp[15:0]);
    end
  endtask

  task automatic set_pair(input logic [4:0] rd0, input logic [4:0] rs1_1, input logic [4:0] rs2_1,
                          input logic [4:0] rd1, input logic w0, input logic w1,
                          input logic u1, input logic u2, input logic v1);
    bus.pair_valid = 1'b1;
    bus.rd0        = rd0;
    bus.rs1_1      = rs1_1;
    bus.rs2_1      = rs2_1;
    bus.rd1        = rd1;
    bus.wr0        = w0;
    bus.wr1        = w1;
    bus.use1_1     = u1;
    bus.use2_1     = u2;
    bus.valid1     = v1;
  endtask

  // One en=1 edge; sampling happens 1ns after it.
  task automatic tick();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  // n en=0 edges; pulses must stay low, busy must hold.
  task automatic gap(input int n, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk_out("gap", {3'b000, exp_busy});
    end
  endtask

  initial begin
    bus.pair_valid = 1'b0;
    bus.valid1     = 1'b0;
    bus.rd0        = '0;
    bus.rs1_0      = '0;
    bus.rs2_0      = '0;
    bus.rd1        = '0;
    bus.rs1_1      = '0;
    bus.rs2_1      = '0;
    bus.wr0        = 1'b0;
    bus.wr1        = 1'b0;
    bus.use1_1     = 1'b0;
    bus.use2_1     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_out", 4'b0000);
    chk_cnt("reset_cnt", 16'h0000, 16'h0000);
    reset = 1'b0;
    gap(2, 1'b0);

    // Independent pair: dual issue.
    set_pair(5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("indep_issue", 4'b1110);
    chk_cnt("indep_cnt", 16'd1, 16'd0);
    gap(49, 1'b0);

    // RAW on rs1_1: split across two ticks.
    set_pair(5'd5, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("raw_t1", 4'b1001);
    chk_cnt("raw_t1_cnt", 16'd1, 16'd1);
    gap(49, 1'b1);
    tick();
    chk_out("raw_t2", 4'b0110);
    chk_cnt("raw_t2_cnt", 16'd1, 16'd1);
    gap(1, 1'b0);

    // x0 destination never hazards.
    set_pair(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("x0_dual", 4'b1110);
    chk_cnt("x0_cnt", 16'd2, 16'd1);
    gap(1, 1'b0);

    // WAW on r7 splits.
    set_pair(5'd7, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("waw_t1", 4'b1001);
    chk_cnt("waw_cnt", 16'd2, 16'd2);
    tick();
    chk_out("waw_t2", 4'b0110);
    gap(1, 1'b0);

    // Single-instruction pair ignores hazard fields, counters untouched.
    set_pair(5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("single", 4'b1010);
    chk_cnt("single_cnt", 16'd2, 16'd2);
    gap(1, 1'b0);

    // No pair presented.
    bus.pair_valid = 1'b0;
    tick();
    chk_out("no_pair", 4'b0000);

    // Pair presented but en low: nothing happens.
    set_pair(5'd5, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    gap(3, 1'b0);
    chk_cnt("en_low_cnt", 16'd2, 16'd2);

    // Flush while in SPLIT: no issue1/ack, back to IDLE.
    tick();
    chk_out("pre_flush", 4'b1001);
    chk_cnt("pre_flush_cnt", 16'd2, 16'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("flush_split", 4'b0000);
    bus.pair_valid = 1'b0;
    tick();
    chk_out("post_flush", 4'b0000);
    chk_cnt("flush_cnt", 16'd2, 16'd3);

    // Flush in IDLE overrides en with a hazard pair present.
    set_pair(5'd5, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("flush_idle", 4'b0000);
    chk_cnt("flush_idle_cnt", 16'd2, 16'd3);

    // Reset asserted mid-SPLIT drops the pending slot1.
    tick();
    chk_out("pre_reset", 4'b1001);
    chk_cnt("pre_reset_cnt", 16'd2, 16'd4);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 4'b0000);
    chk_cnt("async_reset_cnt", 16'd0, 16'd0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset_hold", 4'b0000);
    en    = 1'b0;
    reset = 1'b0;
    bus.pair_valid = 1'b0;
    gap(2, 1'b0);
    tick();
    chk_out("post_reset_idle", 4'b0000);

    // Queue re-presents the pair after reset.
    set_pair(5'd5, 5'd5, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("replay_t1", 4'b1001);
    chk_cnt("replay_cnt", 16'd0, 16'd1);
    tick();
    chk_out("replay_t2", 4'b0110);
    gap(1, 1'b0);

    // Saturation of dual_cnt.
    force dut.dual_cnt_q = 16'hFFFE;
    #1;
    release dut.dual_cnt_q;
    set_pair(5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("sat_1", 4'b1110);
    chk_cnt("sat_1_cnt", 16'hFFFF, 16'd1);
    gap(1, 1'b0);
    tick();
    chk_cnt("sat_2_cnt", 16'hFFFF, 16'd1);
    gap(1, 1'b0);
    tick();
    chk_out("sat_3", 4'b1110);
    chk_cnt("sat_3_cnt", 16'hFFFF, 16'd1);
    gap(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_sequencer.md
DUAL_ISSUE_SEQUENCER -- requirements
Module: dual_issue_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, system clock (hz100 domain); all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-003 SHALL have port en, input, 1, one-clk-wide issue tick from the clock divider; state advances only on edges where en=1.
REQ-004 SHALL have port flush, input, 1, synchronous abort of the current pair.
REQ-005 SHALL have port pair_valid, input, 1, instruction queue presents a pair (slot0 older than slot1).
REQ-006 SHALL have port valid1, input, 1, slot1 holds a real instruction.
REQ-007 SHALL have ports rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1, input, 5 each, register indices.
REQ-008 SHALL have ports wr0, wr1, input, 1 each, slot writes its rd.
REQ-009 SHALL have ports use1_1, use2_1, input, 1 each, slot1 reads rs1_1 / rs2_1.
REQ-010 SHALL have ports issue0, issue1, output, 1 each, datapath enable pulses.
REQ-011 SHALL have port pair_ack, output, 1, pop pulse to the instruction queue.
REQ-012 SHALL have port busy, output, 1, high while in SPLIT.
REQ-013 SHALL have ports dual_cnt, split_cnt, output, 16 each, performance counters.

Function
REQ-014 SHALL implement FSM states IDLE and SPLIT; issue0, issue1 and pair_ack SHALL be registered, one-clk pulses asserted in the clk after the deciding en edge.
REQ-015 SHALL define raw = wr0 & (rd0!=0) & ((use1_1 & rs1_1==rd0) | (use2_1 & rs2_1==rd0)).
REQ-016 SHALL define waw = wr0 & wr1 & (rd0!=0) & (rd0==rd1).
REQ-017 SHALL define hazard = valid1 & (raw | waw); register x0 is never a hazard source.
REQ-018 IDLE, en=1, pair_valid=1, valid1=1, hazard=0: SHALL pulse issue0, issue1 and pair_ack, increment dual_cnt, and remain IDLE.
REQ-019 IDLE, en=1, pair_valid=1, valid1=0: SHALL pulse issue0 and pair_ack only, leave counters unchanged, and remain IDLE.
REQ-020 IDLE, en=1, pair_valid=1, hazard=1: SHALL pulse issue0 only, increment split_cnt, and enter SPLIT.
REQ-021 SPLIT, en=1: SHALL pulse issue1 and pair_ack and return to IDLE; pair_valid is ignored here because the queue holds the pair until ack.
REQ-022 IDLE, en=1, pair_valid=0: SHALL issue nothing and remain IDLE.
REQ-023 en=0 edges SHALL cause no state change and no pulses.
REQ-024 Slot1 SHALL never issue before slot0 of the same pair; issue1 without issue0 occurs only in SPLIT.
REQ-025 flush=1 on any edge SHALL force IDLE with no pulses that cycle, overriding en; counters hold.
REQ-026 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-027 busy SHALL be combinational from state (1 iff SPLIT).

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, issue0=issue1=pair_ack=0, dual_cnt=split_cnt=0.
REQ-029 reset asserted while in SPLIT SHALL discard the pending slot1 issue with no pair_ack; the queue re-presents the pair after reset.
REQ-030 After reset deasserts, the first action SHALL occur on the next en edge.

Verification
REQ-031 Independent pair (rd0=1,rs1_1=2,rs2_1=3,use both, rd1=4, wr both) with en -> issue0=issue1=pair_ack=1 for one clk; dual_cnt=1.
REQ-032 RAW pair (rd0=5, rs1_1=5, use1_1=1) -> tick1: issue0 only, busy=1, split_cnt=1; tick2: issue1+pair_ack, busy=0.
REQ-033 rd0=0 with rs1_1=0, and separately WAW rd0=rd1=7 -> first dual issue, second splits (split_cnt+1).
REQ-034 Flush in SPLIT, then reset asserted mid-SPLIT -> no issue1/pair_ack in either case; reset clears counters to 0.
REQ-035 Force dual_cnt to 16'hFFFE and issue 3 independent pairs -> dual_cnt holds at 16'hFFFF.
REQ-036 Gaps of 49 en=0 clks between ticks -> outputs stay 0 between ticks; each pulse is exactly one clk wide.
